cache_refill_controller: RTL and testbench

CACHE_REFILL_CONTROLLER -- requirements
Module: cache_refill_controller

---
 rtl/cache_refill_controller_pkg.sv | 32 +++
 rtl/cache_refill_controller_refill_buffer.sv | 33 +++
 rtl/cache_refill_controller.sv | 130 +++++++++++++
 tb/tb_cache_refill_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_controller_pkg.sv
// Shared constants for the cache refill controller: word width, address
// field bounds and the refill FSM state encoding.
package cache_refill_controller_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int SETS        = 1024;
  localparam int ADDR_WIDTH  = 15;

  localparam int TAG_HI    = 14;
  localparam int TAG_LO    = 12;
  localparam int INDEX_HI  = 11;
  localparam int INDEX_LO  = 2;
  localparam int OFFSET_HI = 1;
  localparam int OFFSET_LO = 0;

  // A block base is everything above the word offset (tag and index together).
  localparam int BASE_WIDTH = ADDR_WIDTH - (OFFSET_HI - OFFSET_LO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [BASE_WIDTH-1:0] base,
    input logic [1:0]            offset
  );
    return {base, offset};
  endfunction

endpackage

// File: rtl/cache_refill_controller_refill_buffer.sv
// Four-word refill staging buffer; one word written per memory response,
// all words visible for the block write into the cache.
module refill_buffer
  import cache_refill_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [1:0]             widx,
  input  logic [WORD_LENGTH-1:0] wdata,
  output logic [WORD_LENGTH-1:0] word0,
  output logic [WORD_LENGTH-1:0] word1,
  output logic [WORD_LENGTH-1:0] word2,
  output logic [WORD_LENGTH-1:0] word3
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word0 <= '0;
      word1 <= '0;
      word2 <= '0;
      word3 <= '0;
    end else if (we) begin
      case (widx)
        2'd0:    word0 <= wdata;
        2'd1:    word1 <= wdata;
        2'd2:    word2 <= wdata;
        default: word3 <= wdata;
      endcase
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Blocking cache refill controller: on a read miss it fetches the four words
// of the block from memory, then writes the block and forwards the requested word.
module cache_refill_controller
  import cache_refill_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   hit,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   cache_write,
  output logic [WORD_LENGTH-1:0] dataIn1,
  output logic [WORD_LENGTH-1:0] dataIn2,
  output logic [WORD_LENGTH-1:0] dataIn3,
  output logic [WORD_LENGTH-1:0] dataIn4,
  output logic                   stall,
  output logic                   refill_valid,
  output logic [WORD_LENGTH-1:0] refill_word
);

  state_t                 state;
  state_t                 next_state;
  logic [1:0]             counter;
  logic [BASE_WIDTH-1:0]  base;
  logic                   suppress;
  logic                   miss;
  logic                   capture;
  logic [WORD_LENGTH-1:0] slot0;
  logic [WORD_LENGTH-1:0] slot1;
  logic [WORD_LENGTH-1:0] slot2;
  logic [WORD_LENGTH-1:0] slot3;
  logic [WORD_LENGTH-1:0] selected;

  // The cycle right after WRITE still sees the old lookup result for an
  // unchanged address, so a miss there must not start another refill.
  assign miss    = (state == IDLE) && req && !hit && !suppress;
  assign capture = (state == FETCH) && mem_ready;

  refill_buffer u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (capture),
    .widx  (counter),
    .wdata (mem_rdata),
    .word0 (slot0),
    .word1 (slot1),
    .word2 (slot2),
    .word3 (slot3)
  );

  assign dataIn1 = slot3;
  assign dataIn2 = slot2;
  assign dataIn3 = slot1;
  assign dataIn4 = slot0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= 2'd0;
      base     <= '0;
      suppress <= 1'b0;
    end else begin
      suppress <= (state == WRITE);
      if (miss) begin
        base    <= address[TAG_HI:INDEX_LO];
        counter <= 2'd0;
      end else if (capture) begin
        counter <= counter + 2'd1;
      end
    end
  end

  always_comb begin
    selected = slot0;
    case (address[OFFSET_HI:OFFSET_LO])
      2'd0:    selected = slot0;
      2'd1:    selected = slot1;
      2'd2:    selected = slot2;
      default: selected = slot3;
    endcase
  end

  always_comb begin
    next_state   = state;
    mem_read     = 1'b0;
    mem_addr     = '0;
    cache_write  = 1'b0;
    refill_valid = 1'b0;
    refill_word  = '0;
    stall        = 1'b0;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = word_addr(base, counter);
        if (capture && (counter == 2'd3)) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        stall        = 1'b1;
        cache_write  = 1'b1;
        refill_valid = 1'b1;
        refill_word  = selected;
        next_state   = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller: hit, zero-wait and wait-state
// refills, suppression after WRITE, mid-refill reset and stray memory responses.
module tb_cache_refill_controller;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [14:0] address;
  logic        hit;
  logic        mem_read;
  logic [14:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        cache_write;
  logic [31:0] dataIn1;
  logic [31:0] dataIn2;
  logic [31:0] dataIn3;
  logic [31:0] dataIn4;
  logic        stall;
  logic        refill_valid;
  logic [31:0] refill_word;

  int compared;
  int mismatched;

  cache_refill_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .address      (address),
    .hit          (hit),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .cache_write  (cache_write),
    .dataIn1      (dataIn1),
    .dataIn2      (dataIn2),
    .dataIn3      (dataIn3),
    .dataIn4      (dataIn4),
    .stall        (stall),
    .refill_valid (refill_valid),
    .refill_word  (refill_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive processor and memory inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic r, input logic [14:0] a, input logic h,
                               input logic mr, input logic [31:0] md);
    req       = r;
    address   = a;
    hit       = h;
    mem_ready = mr;
    mem_rdata = md;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    req        = 1'b0;
    address    = '0;
    hit        = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;

    // Reset state
    cycle();
    applyStimulus(1'b0, 15'h0000, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_mem_read", {31'b0, mem_read}, 32'd0);
    checkOutput("rst_mem_addr", {17'b0, mem_addr}, 32'd0);
    checkOutput("rst_cache_write", {31'b0, cache_write}, 32'd0);
    checkOutput("rst_refill_valid", {31'b0, refill_valid}, 32'd0);
    checkOutput("rst_refill_word", refill_word, 32'd0);
    checkOutput("rst_dataIn4", dataIn4, 32'd0);
    cycle();
    rst_n = 1'b1;

    // Scenario 1: hit never fetches
    applyStimulus(1'b1, 15'h1234, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_stall", {31'b0, stall}, 32'd0);
    checkOutput("s1_mem_read", {31'b0, mem_read}, 32'd0);
    cycle();
    applyStimulus(1'b1, 15'h1234, 1'b1, 1'b0, 32'h0);
    checkOutput("s1_stall_next", {31'b0, stall}, 32'd0);
    checkOutput("s1_mem_read_next", {31'b0, mem_read}, 32'd0);

    // Scenario 2: zero-wait refill of block 0x5004, requested offset 2
    cycle();
    applyStimulus(1'b1, 15'h5006, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_detect_stall", {31'b0, stall}, 32'd1);
    checkOutput("s2_detect_mem_read", {31'b0, mem_read}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      applyStimulus(1'b1, 15'h5006, 1'b0, 1'b1, 32'hA0 + k);
      checkOutput($sformatf("s2_mem_addr%0d", k), {17'b0, mem_addr}, 32'h5004 + k);
      checkOutput($sformatf("s2_mem_read%0d", k), {31'b0, mem_read}, 32'd1);
      checkOutput($sformatf("s2_stall%0d", k), {31'b0, stall}, 32'd1);
      checkOutput($sformatf("s2_no_write%0d", k), {31'b0, cache_write}, 32'd0);
    end
    cycle();
    applyStimulus(1'b1, 15'h5006, 1'b0, 1'b0, 32'h0);
    checkOutput("s2_cache_write", {31'b0, cache_write}, 32'd1);
    checkOutput("s2_dataIn1", dataIn1, 32'hA3);
    checkOutput("s2_dataIn2", dataIn2, 32'hA2);
    checkOutput("s2_dataIn3", dataIn3, 32'hA1);
    checkOutput("s2_dataIn4", dataIn4, 32'hA0);
    checkOutput("s2_refill_valid", {31'b0, refill_valid}, 32'd1);
    checkOutput("s2_refill_word", refill_word, 32'hA2);
    checkOutput("s2_write_stall", {31'b0, stall}, 32'd1);
    checkOutput("s2_write_mem_read", {31'b0, mem_read}, 32'd0);
    cycle();
    applyStimulus(1'b1, 15'h5006, 1'b1, 1'b0, 32'h0);
    checkOutput("s2_after_stall", {31'b0, stall}, 32'd0);
    checkOutput("s2_after_cache_write", {31'b0, cache_write}, 32'd0);
    checkOutput("s2_after_refill_valid", {31'b0, refill_valid}, 32'd0);

    // Scenario 6: stray responses in IDLE leave the buffer alone
    cycle();
    applyStimulus(1'b0, 15'h0000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("s6_mem_read", {31'b0, mem_read}, 32'd0);
    cycle();
    applyStimulus(1'b0, 15'h0000, 1'b0, 1'b1, 32'hFACE_0000);
    checkOutput("s6_dataIn4", dataIn4, 32'hA0);
    checkOutput("s6_dataIn1", dataIn1, 32'hA3);
    checkOutput("s6_stall", {31'b0, stall}, 32'd0);
    cycle();
    applyStimulus(1'b0, 15'h0000, 1'b0, 1'b0, 32'h0);
    checkOutput("s6_mem_read_after", {31'b0, mem_read}, 32'd0);
    checkOutput("s6_dataIn2", dataIn2, 32'hA2);

    // Scenario 3: three wait cycles per word, block 0x2A08, requested offset 1
    cycle();
    applyStimulus(1'b1, 15'h2A09, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_detect_stall", {31'b0, stall}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        cycle();
        applyStimulus(1'b1, 15'h2A09, 1'b0, 1'b0, 32'h0);
        checkOutput($sformatf("s3_wait_addr%0d_%0d", k, w), {17'b0, mem_addr}, 32'h2A08 + k);
        checkOutput($sformatf("s3_wait_stall%0d_%0d", k, w), {31'b0, stall}, 32'd1);
        checkOutput($sformatf("s3_wait_read%0d_%0d", k, w), {31'b0, mem_read}, 32'd1);
      end
      cycle();
      applyStimulus(1'b1, 15'h2A09, 1'b0, 1'b1, 32'hB0 + k);
      checkOutput($sformatf("s3_ready_addr%0d", k), {17'b0, mem_addr}, 32'h2A08 + k);
      checkOutput($sformatf("s3_ready_stall%0d", k), {31'b0, stall}, 32'd1);
    end
    cycle();
    applyStimulus(1'b1, 15'h2A09, 1'b0, 1'b0, 32'h0);
    checkOutput("s3_cache_write", {31'b0, cache_write}, 32'd1);
    checkOutput("s3_stall", {31'b0, stall}, 32'd1);
    checkOutput("s3_refill_word", refill_word, 32'hB1);
    checkOutput("s3_dataIn1", dataIn1, 32'hB3);
    checkOutput("s3_dataIn4", dataIn4, 32'hB0);

    // Scenario 5: unchanged missing address right after WRITE is ignored
    cycle();
    applyStimulus(1'b1, 15'h2A09, 1'b0, 1'b0, 32'h0);
    checkOutput("s5_suppressed_stall", {31'b0, stall}, 32'd0);
    checkOutput("s5_suppressed_cache_write", {31'b0, cache_write}, 32'd0);
    cycle();
    applyStimulus(1'b1, 15'h7FFE, 1'b0, 1'b0, 32'h0);
    checkOutput("s5_no_fetch", {31'b0, mem_read}, 32'd0);
    checkOutput("s5_new_detect_stall", {31'b0, stall}, 32'd1);
    cycle();
    applyStimulus(1'b1, 15'h7FFE, 1'b0, 1'b1, 32'hC0);
    checkOutput("s5_fetch_read", {31'b0, mem_read}, 32'd1);
    checkOutput("s5_fetch_addr", {17'b0, mem_addr}, 32'h7FFC);

    // Scenario 4: reset after two captured words, then a late response
    cycle();
    applyStimulus(1'b1, 15'h7FFE, 1'b0, 1'b1, 32'hC1);
    checkOutput("s4_addr1", {17'b0, mem_addr}, 32'h7FFD);
    cycle();
    applyStimulus(1'b1, 15'h7FFE, 1'b0, 1'b0, 32'h0);
    checkOutput("s4_addr2", {17'b0, mem_addr}, 32'h7FFE);
    checkOutput("s4_buffer_before_reset", dataIn3, 32'hC1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 15'h7FFE, 1'b0, 1'b0, 32'h0);
    checkOutput("s4_rst_mem_read", {31'b0, mem_read}, 32'd0);
    checkOutput("s4_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("s4_rst_mem_addr", {17'b0, mem_addr}, 32'd0);
    checkOutput("s4_rst_cache_write", {31'b0, cache_write}, 32'd0);
    checkOutput("s4_rst_refill_valid", {31'b0, refill_valid}, 32'd0);
    checkOutput("s4_rst_refill_word", refill_word, 32'd0);
    checkOutput("s4_rst_dataIn4", dataIn4, 32'd0);
    checkOutput("s4_rst_dataIn3", dataIn3, 32'd0);
    cycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, 15'h7FFE, 1'b0, 1'b1, 32'hC2);
    checkOutput("s4_late_mem_read", {31'b0, mem_read}, 32'd0);
    cycle();
    applyStimulus(1'b0, 15'h7FFE, 1'b0, 1'b0, 32'h0);
    checkOutput("s4_late_dataIn2", dataIn2, 32'd0);
    checkOutput("s4_late_stall", {31'b0, stall}, 32'd0);
    checkOutput("s4_late_cache_write", {31'b0, cache_write}, 32'd0);
    checkOutput("s4_late_mem_read2", {31'b0, mem_read}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
